// File: rtl/mc_ctrl.sv
// Multicycle MIPS-subset control unit.
// Moore FSM with registered control outputs.
module mc_ctrl #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       halted
);

  typedef enum logic [3:0] {
    S_INIT  = 4'd0,
    S_IF    = 4'd1,
    S_ID    = 4'd2,
    S_MADDR = 4'd3,
    S_MRD   = 4'd4,
    S_MWB   = 4'd5,
    S_MWR   = 4'd6,
    S_REX   = 4'd7,
    S_RWB   = 4'd8,
    S_BEQ   = 4'd9,
    S_JMP   = 4'd10,
    S_IEX   = 4'd11,
    S_IWB   = 4'd12,
    S_HALT  = 4'd15
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       halted;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t st_q;
  state_t st_d;
  ctrl_t  c_q;
  ctrl_t  c_d;

  logic is_r;
  logic is_mem;
  logic is_beq;
  logic is_j;
  logic is_addi;

  assign is_r    = (opcode == OP_R);
  assign is_mem  = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_beq  = (opcode == OP_BEQ);
  assign is_j    = (opcode == OP_J);
  assign is_addi = (opcode == OP_ADDI);

  // Next-state selection; opcode only matters in ID and MADDR.
  always_comb begin
    st_d = S_INIT;
    unique case (st_q)
      S_INIT:  st_d = S_IF;
      S_IF:    st_d = S_ID;
      S_ID: begin
        unique case (1'b1)
          is_r:    st_d = S_REX;
          is_mem:  st_d = S_MADDR;
          is_beq:  st_d = S_BEQ;
          is_j:    st_d = S_JMP;
          is_addi: st_d = S_IEX;
          default: st_d = ILLEGAL_HALT ? S_HALT : S_IF;
        endcase
      end
      S_MADDR: st_d = (opcode == OP_LW) ? S_MRD : S_MWR;
      S_MRD:   st_d = S_MWB;
      S_MWB:   st_d = S_IF;
      S_MWR:   st_d = S_IF;
      S_REX:   st_d = S_RWB;
      S_RWB:   st_d = S_IF;
      S_BEQ:   st_d = S_IF;
      S_JMP:   st_d = S_IF;
      S_IEX:   st_d = S_IWB;
      S_IWB:   st_d = S_IF;
      S_HALT:  st_d = S_HALT;
      default: st_d = S_INIT;
    endcase
  end

  // Control decode of the upcoming state, so outputs register alongside it.
  always_comb begin
    c_d = '0;
    unique case (st_d)
      S_IF: begin
        c_d.mem_read  = 1'b1;
        c_d.ir_write  = 1'b1;
        c_d.alu_src_b = 2'b01;
        c_d.pc_write  = 1'b1;
      end
      S_ID: c_d.alu_src_b = 2'b11;
      S_MADDR: begin
        c_d.alu_src_a = 1'b1;
        c_d.alu_src_b = 2'b10;
      end
      S_MRD: begin
        c_d.mem_read = 1'b1;
        c_d.iord     = 1'b1;
      end
      S_MWB: begin
        c_d.reg_write  = 1'b1;
        c_d.mem_to_reg = 1'b1;
      end
      S_MWR: begin
        c_d.mem_write = 1'b1;
        c_d.iord      = 1'b1;
      end
      S_REX: begin
        c_d.alu_src_a = 1'b1;
        c_d.alu_op    = 2'b10;
      end
      S_RWB: begin
        c_d.reg_write = 1'b1;
        c_d.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        c_d.alu_src_a     = 1'b1;
        c_d.alu_op        = 2'b01;
        c_d.pc_write_cond = 1'b1;
        c_d.pc_source     = 2'b01;
      end
      S_JMP: begin
        c_d.pc_write  = 1'b1;
        c_d.pc_source = 2'b10;
      end
      S_IEX: begin
        c_d.alu_src_a = 1'b1;
        c_d.alu_src_b = 2'b10;
      end
      S_IWB:  c_d.reg_write = 1'b1;
      S_HALT: c_d.halted    = 1'b1;
      default: c_d = '0;
    endcase
  end

  // State and control registers; reset parks in INIT with everything low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= S_INIT;
      c_q  <= '0;
    end else begin
      st_q <= st_d;
      c_q  <= c_d;
    end
  end

  assign IRWrite     = c_q.ir_write;
  assign PCWrite     = c_q.pc_write;
  assign PCWriteCond = c_q.pc_write_cond;
  assign IorD        = c_q.iord;
  assign MemRead     = c_q.mem_read;
  assign MemWrite    = c_q.mem_write;
  assign MemtoReg    = c_q.mem_to_reg;
  assign RegDst      = c_q.reg_dst;
  assign RegWrite    = c_q.reg_write;
  assign ALUSrcA     = c_q.alu_src_a;
  assign ALUSrcB     = c_q.alu_src_b;
  assign ALUOp       = c_q.alu_op;
  assign PCSource    = c_q.pc_source;
  assign halted      = c_q.halted;
  assign state       = st_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: expected state/control
// sequences queued per instruction, checked each cycle.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rst0 = 1'b0;
  logic       rst1 = 1'b0;
  logic [5:0] op0 = 6'd0;
  logic [5:0] op1 = 6'd0;
  wire [16:0] v0;
  wire [16:0] v1;
  wire [3:0]  st0;
  wire [3:0]  st1;

  int checks = 0;
  int failures = 0;
  int q[$];

  always #5 clk = ~clk;

  mc_ctrl #(.ILLEGAL_HALT(1'b0)) u0 (
    .clk(clk), .rst_n(rst0), .opcode(op0),
    .IRWrite(v0[16]), .PCWrite(v0[15]),
    .PCWriteCond(v0[14]), .IorD(v0[13]),
    .MemRead(v0[12]), .MemWrite(v0[11]),
    .MemtoReg(v0[10]), .RegDst(v0[9]),
    .RegWrite(v0[8]), .ALUSrcA(v0[7]),
    .ALUSrcB(v0[6:5]), .ALUOp(v0[4:3]),
    .PCSource(v0[2:1]), .state(st0),
    .halted(v0[0])
  );

  mc_ctrl #(.ILLEGAL_HALT(1'b1)) u1 (
    .clk(clk), .rst_n(rst1), .opcode(op1),
    .IRWrite(v1[16]), .PCWrite(v1[15]),
    .PCWriteCond(v1[14]), .IorD(v1[13]),
    .MemRead(v1[12]), .MemWrite(v1[11]),
    .MemtoReg(v1[10]), .RegDst(v1[9]),
    .RegWrite(v1[8]), .ALUSrcA(v1[7]),
    .ALUSrcB(v1[6:5]), .ALUOp(v1[4:3]),
    .PCSource(v1[2:1]), .state(st1),
    .halted(v1[0])
  );

  // Reference control table, written from the state descriptions.
  function automatic logic [16:0] exp_vec(input int s);
    logic [16:0] v;
    v = '0;
    case (s)
      1: begin
        v[16] = 1'b1; v[15] = 1'b1;
        v[12] = 1'b1; v[6:5] = 2'b01;
      end
      2: v[6:5] = 2'b11;
      3: begin v[7] = 1'b1; v[6:5] = 2'b10; end
      4: begin v[12] = 1'b1; v[13] = 1'b1; end
      5: begin v[8] = 1'b1; v[10] = 1'b1; end
      6: begin v[11] = 1'b1; v[13] = 1'b1; end
      7: begin v[7] = 1'b1; v[4:3] = 2'b10; end
      8: begin v[8] = 1'b1; v[9] = 1'b1; end
      9: begin
        v[7] = 1'b1; v[4:3] = 2'b01;
        v[14] = 1'b1; v[2:1] = 2'b01;
      end
      10: begin v[15] = 1'b1; v[2:1] = 2'b10; end
      11: begin v[7] = 1'b1; v[6:5] = 2'b10; end
      12: v[8] = 1'b1;
      15: v[0] = 1'b1;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic step(input int sel);
    int e;
    logic [3:0] s;
    logic [16:0] v;
    logic [16:0] ev;
    logic [3:0] es;
    @(negedge clk);
    e = q.pop_front();
    es = e[3:0];
    ev = exp_vec(e);
    s = (sel != 0) ? st1 : st0;
    v = (sel != 0) ? v1 : v0;
    checks++;
    assert (s === es) else begin
      failures++;
      $error("FAIL state dut%0d obs=%0d exp=%0d", sel, s, es);
    end
    checks++;
    assert (v === ev) else begin
      failures++;
      $error("FAIL ctrl dut%0d st=%0d obs=%h exp=%h",
             sel, es, v, ev);
    end
    checks++;
    assert (!(v[12] && v[11]) && !(v[15] && v[14])
            && (!v[16] || s == 4'd1)) else begin
      failures++;
      $error("FAIL invariant dut%0d obs=%h exp=exclusive",
             sel, v);
    end
  endtask

  // Drain the queued instruction; opcode appears once IF has loaded it.
  task automatic run(input int sel, input logic [5:0] op);
    step(sel);
    if (sel != 0) op1 = op;
    else op0 = op;
    while (q.size() > 0) step(sel);
  endtask

  initial begin
    #3;
    checks++;
    assert (st0 === 4'd0 && v0 === 17'd0) else begin
      failures++;
      $error("FAIL reset obs=%0d/%h exp=0/0", st0, v0);
    end
    @(negedge clk);
    q.push_back(0);
    step(0);
    rst0 = 1'b1;

    q = '{1, 2, 3, 4, 5};
    run(0, 6'b100011);
    q = '{1, 2, 3, 6};
    run(0, 6'b101011);
    q = '{1, 2, 7, 8};
    run(0, 6'b000000);
    q = '{1, 2, 11, 12};
    run(0, 6'b001000);
    q = '{1, 2, 9};
    run(0, 6'b000100);
    q = '{1, 2, 10};
    run(0, 6'b000010);
    q = '{1, 2};
    run(0, 6'b111111);
    q = '{1, 2, 3, 4};
    run(0, 6'b100011);

    #2 rst0 = 1'b0;
    #1;
    checks++;
    assert (st0 === 4'd0 && v0[12] === 1'b0 && v0 === 17'd0)
    else begin
      failures++;
      $error("FAIL async_rst obs=%0d/%h exp=0/0", st0, v0);
    end
    q.push_back(0);
    step(0);
    rst0 = 1'b1;
    q = '{1, 2, 7, 8, 1};
    run(0, 6'b000000);

    rst1 = 1'b1;
    q = '{1, 2, 15};
    run(1, 6'b111111);
    for (int i = 0; i < 20; i++) begin
      op1 = 6'($urandom);
      q.push_back(15);
      step(1);
    end
    #2 rst1 = 1'b0;
    #1;
    checks++;
    assert (st1 === 4'd0 && v1 === 17'd0) else begin
      failures++;
      $error("FAIL halt_rst obs=%0d/%h exp=0/0", st1, v1);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
